// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron compute elements: activation modes,
// FSM states, accumulator sizing and the shift/saturate used on results.
package neuron_pkg;

   typedef enum logic [1:0] {
      ACT_STEP  = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_IDENT = 2'd2
   } act_mode_e;

   typedef enum logic {
      S_ACC = 1'b0,
      S_OUT = 1'b1
   } neuron_state_e;

   // Widest accumulator sat_shift can handle; callers sign-extend into it.
   localparam int MAX_ACC_W = 128;
   typedef logic signed [MAX_ACC_W-1:0] wide_t;

   // Smallest accumulator that holds bias plus input_count full-width products.
   function automatic int acc_w_min(input int data_w, input int input_count);
      return 2*data_w + $clog2(input_count) + 1;
   endfunction

   // Drop frac_w fraction bits (floor), then clamp to a signed data_w range.
   function automatic wide_t sat_shift(input wide_t acc, input int frac_w, input int data_w);
      wide_t r, hi, lo;
      r  = acc >>> frac_w;
      hi = (wide_t'(1) <<< (data_w-1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (data_w-1));
      if (r > hi)      return hi;
      else if (r < lo) return lo;
      else             return r;
   endfunction

endpackage

// File: rtl/neuron_activation.sv
// Combinational result path: accumulator -> fixed-point rescale -> saturate ->
// step / ReLU / identity. Pure logic so layer engines can register it as they like.
module neuron_activation
   import neuron_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 8,
   parameter int ACC_W    = 40,
   parameter int ACT_MODE = 0
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [DATA_W-1:0] threshold,
   output logic signed [DATA_W-1:0] result
);

   localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

   if (ACT_MODE != int'(ACT_STEP) && ACT_MODE != int'(ACT_RELU) && ACT_MODE != int'(ACT_IDENT)) begin : g_bad_mode
      $error("neuron_activation: unsupported ACT_MODE %0d", ACT_MODE);
   end
   if (ACC_W > MAX_ACC_W) begin : g_bad_acc
      $error("neuron_activation: ACC_W %0d exceeds %0d", ACC_W, MAX_ACC_W);
   end

   logic signed [DATA_W-1:0] sat;

   assign sat = DATA_W'(sat_shift(MAX_ACC_W'(acc), FRAC_W, DATA_W));

   always_comb begin
      result = sat;
      case (ACT_MODE)
         int'(ACT_STEP):  result = (sat > threshold) ? ONE : '0;
         int'(ACT_RELU):  result = sat[DATA_W-1] ? '0 : sat;
         default:         result = sat;
      endcase
   end

endmodule

// File: rtl/seq_mac_neuron.sv
// Sequential neuron: streams INPUT_COUNT (x, w) beats into a signed accumulator
// seeded with bias, then presents the activated, saturated result on a valid/ready port.
module seq_mac_neuron
   import neuron_pkg::*;
#(
   parameter int INPUT_COUNT = 4,
   parameter int DATA_W      = 16,
   parameter int FRAC_W      = 8,
   parameter int ACC_W       = 40,
   parameter int ACT_MODE    = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_x,
   input  logic signed [DATA_W-1:0] in_w,
   input  logic signed [DATA_W-1:0] bias,
   input  logic signed [DATA_W-1:0] threshold,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     busy
);

   localparam int CNT_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(INPUT_COUNT-1);

   if (INPUT_COUNT < 1) begin : g_bad_cnt
      $error("seq_mac_neuron: INPUT_COUNT must be >= 1");
   end
   if (ACC_W < acc_w_min(DATA_W, INPUT_COUNT)) begin : g_bad_acc
      $error("seq_mac_neuron: ACC_W %0d below minimum %0d", ACC_W, acc_w_min(DATA_W, INPUT_COUNT));
   end

   neuron_state_e             state, state_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic signed [ACC_W-1:0]   acc, acc_nxt, acc_sum;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [DATA_W-1:0]  thr, thr_sel, act_res;
   logic                      first, accept, busy_nxt, load_out;

   // First beat of a frame reseeds from bias instead of the stale accumulator,
   // so neither clear nor reset needs to zero acc.
   assign first   = (cnt == '0);
   assign accept  = in_valid & in_ready & ~clear;
   assign prod    = (2*DATA_W)'(in_x) * (2*DATA_W)'(in_w);
   assign acc_sum = (first ? (ACC_W'(bias) <<< FRAC_W) : acc) + ACC_W'(prod);
   assign thr_sel = first ? threshold : thr;

   assign out_valid = (state == S_OUT);

   neuron_activation #(
      .DATA_W  (DATA_W),
      .FRAC_W  (FRAC_W),
      .ACC_W   (ACC_W),
      .ACT_MODE(ACT_MODE)
   ) u_act (
      .acc      (acc_sum),
      .threshold(thr_sel),
      .result   (act_res)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      acc_nxt   = acc;
      busy_nxt  = busy;
      load_out  = 1'b0;
      if (clear) begin
         state_nxt = S_ACC;
         cnt_nxt   = '0;
         busy_nxt  = 1'b0;
      end else begin
         case (state)
            S_ACC: begin
               if (accept) begin
                  acc_nxt  = acc_sum;
                  busy_nxt = 1'b1;
                  if (cnt == LAST) begin
                     cnt_nxt   = '0;
                     state_nxt = S_OUT;
                     load_out  = 1'b1;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  state_nxt = S_ACC;
                  busy_nxt  = 1'b0;
               end
            end
            default: state_nxt = S_ACC;
         endcase
      end
   end

   // in_ready is registered off the next state, which keeps it low for the
   // handshake cycle and through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_ACC;
         cnt      <= '0;
         acc      <= '0;
         thr      <= '0;
         out_data <= '0;
         busy     <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         acc      <= acc_nxt;
         busy     <= busy_nxt;
         in_ready <= (state_nxt == S_ACC);
         if (accept && first) thr <= threshold;
         if (load_out) out_data <= act_res;
      end
   end

endmodule

// File: tb/tb_seq_mac_neuron.sv
// Bench for seq_mac_neuron: one instance per activation mode on shared stimulus,
// each checked against an arithmetic reference of the frame.
module tb_seq_mac_neuron;

   localparam int N = 4;

   logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] in_x = '0, in_w = '0, bias = '0, threshold = '0;
   wire  [2:0]  rdy, ov, bsy;
   wire  [2:0][15:0] od;

   int n_chk = 0;
   int n_fail = 0;

   logic signed [15:0] fx [N];
   logic signed [15:0] fw [N];
   logic signed [15:0] fb, ft;

   always #5 clk = ~clk;

   seq_mac_neuron #(.INPUT_COUNT(N), .DATA_W(16), .FRAC_W(8), .ACC_W(40), .ACT_MODE(0)) u_step (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_x(in_x), .in_w(in_w), .bias(bias), .threshold(threshold),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bsy[0]));

   seq_mac_neuron #(.INPUT_COUNT(N), .DATA_W(16), .FRAC_W(8), .ACC_W(40), .ACT_MODE(1)) u_relu (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_x(in_x), .in_w(in_w), .bias(bias), .threshold(threshold),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bsy[1]));

   seq_mac_neuron #(.INPUT_COUNT(N), .DATA_W(16), .FRAC_W(8), .ACC_W(40), .ACT_MODE(2)) u_ident (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_x(in_x), .in_w(in_w), .bias(bias), .threshold(threshold),
      .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bsy[2]));

   // Reference: real-valued dot product in 1/65536 units, floor to 1/256, clamp, activate.
   function automatic logic [15:0] model(input int mode);
      longint acc, r;
      acc = longint'(fb) * 256;
      for (int i = 0; i < N; i++) acc += longint'(fx[i]) * longint'(fw[i]);
      r = acc >>> 8;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      case (mode)
         0:       return (r > longint'(ft)) ? 16'h0100 : 16'h0000;
         1:       return (r < 0) ? 16'h0000 : 16'(r);
         default: return 16'(r);
      endcase
   endfunction

   task automatic set_frame(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b, input logic [15:0] t);
      for (int i = 0; i < N; i++) begin fx[i] = x; fw[i] = w; end
      fb = b; ft = t;
   endtask

   task automatic rand_frame();
      for (int i = 0; i < N; i++) begin fx[i] = 16'($urandom); fw[i] = 16'($urandom); end
      fb = 16'($urandom); ft = 16'($urandom);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (rdy[2] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      n_chk++;
      if (rdy[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready timeout: got %b want 1", tag, rdy[2]);
      end
   endtask

   // Enters and leaves just after a falling edge; bias/threshold are scrambled
   // after the first beat so only the first-beat sample may matter.
   task automatic send_beats(input int cnt, input bit gaps, input string tag);
      for (int i = 0; i < cnt; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0; in_x = 16'($urandom); in_w = 16'($urandom);
            @(negedge clk);
         end
         in_valid  = 1'b1;
         in_x      = fx[i];
         in_w      = fw[i];
         bias      = (i == 0) ? fb : 16'($urandom);
         threshold = (i == 0) ? ft : 16'($urandom);
         wait_ready(tag);
         @(negedge clk);
         in_valid = 1'b0;
         bias = 16'($urandom); threshold = 16'($urandom);
         if (i < cnt-1) begin
            n_chk++;
            if (bsy !== 3'b111 || ov !== 3'b000) begin
               n_fail++;
               $display("FAIL %s mid-frame busy/out_valid: got %b/%b want 111/000", tag, bsy, ov);
            end
         end
      end
   endtask

   task automatic run_frame(input string tag, input bit gaps, input int hold, input bit drop);
      logic [15:0] exp [3];
      for (int m = 0; m < 3; m++) exp[m] = model(m);
      n_chk++;
      if (bsy !== 3'b000) begin
         n_fail++;
         $display("FAIL %s idle busy: got %b want 000", tag, bsy);
      end
      send_beats(N, gaps, tag);
      n_chk++;
      if (ov !== 3'b111) begin
         n_fail++;
         $display("FAIL %s out_valid latency: got %b want 111", tag, ov);
      end
      for (int m = 0; m < 3; m++) begin
         n_chk++;
         if (od[m] !== exp[m]) begin
            n_fail++;
            $display("FAIL %s out_data mode %0d: got %h want %h", tag, m, od[m], exp[m]);
         end
      end
      for (int c = 0; c < hold; c++) begin
         in_valid = 1'b1; in_x = 16'($urandom); in_w = 16'($urandom); bias = 16'($urandom);
         @(negedge clk);
         n_chk++;
         if (ov !== 3'b111 || rdy !== 3'b000 || bsy !== 3'b111 ||
             od[0] !== exp[0] || od[1] !== exp[1] || od[2] !== exp[2]) begin
            n_fail++;
            $display("FAIL %s hold cycle %0d: valid %b ready %b busy %b data %h/%h/%h want 111 000 111 %h/%h/%h",
                     tag, c, ov, rdy, bsy, od[0], od[1], od[2], exp[0], exp[1], exp[2]);
         end
      end
      in_valid = 1'b0;
      if (drop) clear = 1'b1; else out_ready = 1'b1;
      @(negedge clk);
      clear = 1'b0; out_ready = 1'b0;
      n_chk++;
      if (ov !== 3'b000 || bsy !== 3'b000 || rdy !== 3'b111) begin
         n_fail++;
         $display("FAIL %s after take: valid %b busy %b ready %b want 000 000 111", tag, ov, bsy, rdy);
      end
   endtask

   task automatic test_reset();
      #1;
      n_chk++;
      if (ov !== 3'b000 || bsy !== 3'b000 || rdy !== 3'b000 || od !== '0) begin
         n_fail++;
         $display("FAIL reset state: valid %b busy %b ready %b data %h want 000 000 000 0", ov, bsy, rdy, od);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (rdy !== 3'b111) begin
         n_fail++;
         $display("FAIL reset in_ready: got %b want 111", rdy);
      end
   endtask

   task automatic test_directed();
      set_frame(16'h0100, 16'h0040, 16'h0000, 16'h0080); run_frame("ident_step_lo", 0, 0, 0);
      set_frame(16'h0100, 16'h0040, 16'h0000, 16'h0100); run_frame("step_equal", 0, 0, 0);
      set_frame(16'h0100, 16'hFFC0, 16'h0020, 16'h0000); run_frame("relu_neg", 0, 0, 0);
      set_frame(16'h0100, 16'hFFC0, 16'h0200, 16'h0000); run_frame("relu_pos", 0, 0, 0);
      set_frame(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000); run_frame("sat_pos", 0, 0, 0);
      set_frame(16'h7FFF, 16'h8000, 16'h0000, 16'h0000); run_frame("sat_neg", 0, 0, 0);
   endtask

   task automatic test_random();
      for (int f = 0; f < 25; f++) begin
         rand_frame();
         run_frame($sformatf("rand%0d", f), 1'b1, $urandom_range(0, 2), 1'b0);
      end
   endtask

   task automatic test_backpressure();
      rand_frame(); run_frame("backpressure", 0, 5, 0);
      rand_frame(); run_frame("bp_next", 1, 0, 0);
   endtask

   task automatic test_clear();
      rand_frame();
      send_beats(2, 0, "clear_mid");
      in_valid = 1'b1; in_x = fx[2]; in_w = fw[2]; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      n_chk++;
      if (bsy !== 3'b000 || ov !== 3'b000 || rdy !== 3'b111) begin
         n_fail++;
         $display("FAIL clear_mid state: busy %b valid %b ready %b want 000 000 111", bsy, ov, rdy);
      end
      fb = 16'($urandom);
      run_frame("clear_new", 1, 0, 0);
      rand_frame(); run_frame("clear_pending", 0, 1, 1);
      rand_frame(); run_frame("clear_after", 0, 0, 0);
   endtask

   task automatic test_reset_mid_frame();
      rand_frame();
      send_beats(2, 0, "rst_mid");
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (bsy !== 3'b000 || ov !== 3'b000 || rdy !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_mid async: busy %b valid %b ready %b want 000 000 000", bsy, ov, rdy);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      run_frame("rst_mid_frame", 0, 0, 0);
      send_beats(N, 0, "rst_pending");
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (ov !== 3'b000 || od !== '0) begin
         n_fail++;
         $display("FAIL rst_pending async: valid %b data %h want 000 0", ov, od);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      run_frame("rst_pending_frame", 0, 0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_clear();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
